// File: rtl/host_link_ctrl_if.sv
// Host link bundle: UART byte stream, memory command port and core control between
// host_link_ctrl (master) and the rest of the system (slave).
interface host_link_ctrl_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        end_process;
  logic [15:0] com_data_out;
  logic [1:0]  status;
  logic [15:0] com_data_in;
  logic [15:0] com_addr;
  logic        com_wr_en;
  logic [3:0]  n_cores;

  modport master (
    input  rx_data, rx_valid, tx_ready, end_process, com_data_out,
    output tx_data, tx_valid, status, com_data_in, com_addr, com_wr_en, n_cores
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, end_process, com_data_out,
    input  tx_data, tx_valid, status, com_data_in, com_addr, com_wr_en, n_cores
  );
endinterface

// File: rtl/host_link_ctrl.sv
// Host command front end: 'L' loads data memory, 'R' runs the cores, 'P' dumps memory.
// Define HOST_LINK_CHECKSUM_EN to make the 'L' ack the XOR of the payload bytes instead of 'K'.
module host_link_ctrl #(
  parameter logic [1:0] ST_IDLE     = 2'b00,
  parameter logic [1:0] ST_MEM      = 2'b01,
  parameter logic [1:0] ST_RUN      = 2'b10,
  parameter int         RD_LAT      = 1,
  parameter int         RUN_TIMEOUT = 0
) (
  input logic             clk,
  input logic             rst_n,
  host_link_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_HDR, S_LD_HI, S_LD_LO, S_LD_WR, S_RUN,
    S_DP_ADDR, S_DP_WAIT, S_DP_TXH, S_DP_TXL, S_TX_ACK
  } state_t;

  localparam logic [7:0]  CMD_L      = 8'h4C;
  localparam logic [7:0]  CMD_R      = 8'h52;
  localparam logic [7:0]  CMD_P      = 8'h50;
  localparam logic [7:0]  RSP_DONE   = 8'h44;
  localparam logic [7:0]  RSP_TMO    = 8'h54;
  localparam logic [7:0]  RSP_ERR    = 8'h3F;
  localparam logic [7:0]  RSP_OK     = 8'h4B;
  localparam logic [1:0]  RD_LAT_L   = 2'(RD_LAT);
  localparam logic [31:0] RUN_LAST   = 32'(RUN_TIMEOUT) - 32'd1;
  localparam bit          TIMEOUT_EN = (RUN_TIMEOUT > 0);

  state_t      state_r, state_s;
  logic [7:0]  cmd_r, cmd_s;
  logic [1:0]  hdr_cnt_r, hdr_cnt_s;
  logic [15:0] addr_r, addr_s;
  logic [15:0] count_r, count_s;
  logic [7:0]  hi_r, hi_s;
  logic [7:0]  lo_r, lo_s;
  logic [1:0]  wait_r, wait_s;
  logic [31:0] run_cnt_r, run_cnt_s;
  logic [7:0]  tx_data_r, tx_data_s;
  logic        tx_valid_r, tx_valid_s;
  logic [1:0]  status_r, status_s;
  logic [15:0] com_addr_r, com_addr_s;
  logic [15:0] com_data_in_r, com_data_in_s;
  logic        com_wr_en_r, com_wr_en_s;
  logic [3:0]  n_cores_r, n_cores_s;
  logic [7:0]  ack_s;

`ifdef HOST_LINK_CHECKSUM_EN
  logic [7:0] chk_r, chk_s;

  function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  assign ack_s = chk_r;
`else
  assign ack_s = RSP_OK;
`endif

  // Next-state and next-output logic for the command sequencer
  always_comb begin
    state_s       = state_r;
    cmd_s         = cmd_r;
    hdr_cnt_s     = hdr_cnt_r;
    addr_s        = addr_r;
    count_s       = count_r;
    hi_s          = hi_r;
    lo_s          = lo_r;
    wait_s        = wait_r;
    run_cnt_s     = run_cnt_r;
    tx_data_s     = tx_data_r;
    tx_valid_s    = tx_valid_r;
    status_s      = status_r;
    com_addr_s    = com_addr_r;
    com_data_in_s = com_data_in_r;
    com_wr_en_s   = 1'b0;
    n_cores_s     = n_cores_r;
`ifdef HOST_LINK_CHECKSUM_EN
    chk_s         = chk_r;
`endif
    case (state_r)
      S_IDLE: begin
        if (bus.rx_valid) begin
          cmd_s     = bus.rx_data;
          hdr_cnt_s = 2'd0;
`ifdef HOST_LINK_CHECKSUM_EN
          chk_s     = 8'h00;
`endif
          if (bus.rx_data == CMD_L || bus.rx_data == CMD_P || bus.rx_data == CMD_R) begin
            state_s = S_HDR;
          end else begin
            tx_data_s  = RSP_ERR;
            tx_valid_s = 1'b1;
            state_s    = S_TX_ACK;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_HDR: begin
        if (bus.rx_valid) begin
          if (cmd_r == CMD_R) begin
            n_cores_s = bus.rx_data[3:0];
            status_s  = ST_RUN;
            run_cnt_s = 32'd0;
            state_s   = S_RUN;
          end else begin
            status_s  = ST_MEM;
            hdr_cnt_s = hdr_cnt_r + 2'd1;
            case (hdr_cnt_r)
              2'd0: addr_s[15:8]  = bus.rx_data;
              2'd1: addr_s[7:0]   = bus.rx_data;
              2'd2: count_s[15:8] = bus.rx_data;
              default: begin
                count_s[7:0] = bus.rx_data;
                // An empty transfer touches no memory: 'L' acks at once, 'P' ends silently
                if ({count_r[15:8], bus.rx_data} == 16'd0) begin
                  if (cmd_r == CMD_L) begin
                    tx_data_s  = ack_s;
                    tx_valid_s = 1'b1;
                    state_s    = S_TX_ACK;
                  end else begin
                    status_s = ST_IDLE;
                    state_s  = S_IDLE;
                  end
                end else if (cmd_r == CMD_L) begin
                  state_s = S_LD_HI;
                end else begin
                  state_s = S_DP_ADDR;
                end
              end
            endcase
          end
        end else begin
          state_s = S_HDR;
        end
      end
      S_LD_HI: begin
        if (bus.rx_valid) begin
          hi_s    = bus.rx_data;
`ifdef HOST_LINK_CHECKSUM_EN
          chk_s   = chk_fold(chk_r, bus.rx_data);
`endif
          state_s = S_LD_LO;
        end else begin
          state_s = S_LD_HI;
        end
      end
      S_LD_LO: begin
        if (bus.rx_valid) begin
          com_addr_s    = addr_r;
          com_data_in_s = {hi_r, bus.rx_data};
          com_wr_en_s   = 1'b1;
          addr_s        = addr_r + 16'd1;
          count_s       = count_r - 16'd1;
`ifdef HOST_LINK_CHECKSUM_EN
          chk_s         = chk_fold(chk_r, bus.rx_data);
`endif
          state_s       = S_LD_WR;
        end else begin
          state_s = S_LD_LO;
        end
      end
      S_LD_WR: begin
        if (count_r == 16'd0) begin
          tx_data_s  = ack_s;
          tx_valid_s = 1'b1;
          state_s    = S_TX_ACK;
        end else begin
          state_s = S_LD_HI;
        end
      end
      S_RUN: begin
        run_cnt_s = (run_cnt_r == 32'hFFFF_FFFF) ? run_cnt_r : run_cnt_r + 32'd1;
        // run_cnt_r is zero only in the first RUN cycle, where end_process may be stale
        if (run_cnt_r != 32'd0 && bus.end_process) begin
          n_cores_s  = 4'd0;
          status_s   = ST_IDLE;
          tx_data_s  = RSP_DONE;
          tx_valid_s = 1'b1;
          state_s    = S_TX_ACK;
        end else if (TIMEOUT_EN && run_cnt_r == RUN_LAST) begin
          n_cores_s  = 4'd0;
          status_s   = ST_IDLE;
          tx_data_s  = RSP_TMO;
          tx_valid_s = 1'b1;
          state_s    = S_TX_ACK;
        end else begin
          state_s = S_RUN;
        end
      end
      S_DP_ADDR: begin
        com_addr_s = addr_r;
        wait_s     = 2'd0;
        state_s    = S_DP_WAIT;
      end
      S_DP_WAIT: begin
        if (wait_r == RD_LAT_L) begin
          tx_data_s  = bus.com_data_out[15:8];
          lo_s       = bus.com_data_out[7:0];
          tx_valid_s = 1'b1;
          state_s    = S_DP_TXH;
        end else begin
          wait_s = wait_r + 2'd1;
        end
      end
      S_DP_TXH: begin
        if (bus.tx_ready) begin
          tx_data_s = lo_r;
          state_s   = S_DP_TXL;
        end else begin
          state_s = S_DP_TXH;
        end
      end
      S_DP_TXL: begin
        if (bus.tx_ready) begin
          tx_valid_s = 1'b0;
          addr_s     = addr_r + 16'd1;
          count_s    = count_r - 16'd1;
          if (count_r == 16'd1) begin
            status_s = ST_IDLE;
            state_s  = S_IDLE;
          end else begin
            state_s = S_DP_ADDR;
          end
        end else begin
          state_s = S_DP_TXL;
        end
      end
      S_TX_ACK: begin
        if (bus.tx_ready) begin
          tx_valid_s = 1'b0;
          status_s   = ST_IDLE;
          state_s    = S_IDLE;
        end else begin
          state_s = S_TX_ACK;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= S_IDLE;
      cmd_r         <= 8'h00;
      hdr_cnt_r     <= 2'd0;
      addr_r        <= 16'h0000;
      count_r       <= 16'h0000;
      hi_r          <= 8'h00;
      lo_r          <= 8'h00;
      wait_r        <= 2'd0;
      run_cnt_r     <= 32'd0;
      tx_data_r     <= 8'h00;
      tx_valid_r    <= 1'b0;
      status_r      <= ST_IDLE;
      com_addr_r    <= 16'h0000;
      com_data_in_r <= 16'h0000;
      com_wr_en_r   <= 1'b0;
      n_cores_r     <= 4'd0;
`ifdef HOST_LINK_CHECKSUM_EN
      chk_r         <= 8'h00;
`endif
    end else begin
      state_r       <= state_s;
      cmd_r         <= cmd_s;
      hdr_cnt_r     <= hdr_cnt_s;
      addr_r        <= addr_s;
      count_r       <= count_s;
      hi_r          <= hi_s;
      lo_r          <= lo_s;
      wait_r        <= wait_s;
      run_cnt_r     <= run_cnt_s;
      tx_data_r     <= tx_data_s;
      tx_valid_r    <= tx_valid_s;
      status_r      <= status_s;
      com_addr_r    <= com_addr_s;
      com_data_in_r <= com_data_in_s;
      com_wr_en_r   <= com_wr_en_s;
      n_cores_r     <= n_cores_s;
`ifdef HOST_LINK_CHECKSUM_EN
      chk_r         <= chk_s;
`endif
    end
  end

  assign bus.tx_data     = tx_data_r;
  assign bus.tx_valid    = tx_valid_r;
  assign bus.status      = status_r;
  assign bus.com_addr    = com_addr_r;
  assign bus.com_data_in = com_data_in_r;
  assign bus.com_wr_en   = com_wr_en_r;
  assign bus.n_cores     = n_cores_r;

endmodule
